// File: rtl/reg_write_pkg.sv
// Shared types and constants for the signal generator register-write master.
package reg_write_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } wr_state_t;

  localparam int unsigned REG_ADDR_W      = 3;
  localparam int unsigned REG_DATA_W      = 5;
  localparam int unsigned CMD_W           = REG_ADDR_W + REG_DATA_W;

  localparam int unsigned DEF_SETUP_CYC   = 60;
  localparam int unsigned DEF_STROBE_CYC  = 120;
  localparam int unsigned DEF_HOLD_CYC    = 60;

  // Divide ratio of the generator clock; the phase defaults span >= 1 scaled period.
  localparam int unsigned GEN_CLK_SCALE   = 50;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for write commands; pushes while full and pops while empty are dropped.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/reg_write_master.sv
// Replays buffered register writes as setup/strobe/hold pulses slow enough for the
// generator's divided clock to capture.
module reg_write_master
  import reg_write_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [REG_ADDR_W-1:0]   cmd_addr_i,
  input  logic [REG_DATA_W-1:0]   cmd_data_i,
  output logic [REG_ADDR_W-1:0]   bus_addr_o,
  output logic [REG_DATA_W-1:0]   bus_data_o,
  output logic                    bus_strobe_o,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam logic [CNT_W-1:0] SetupLd  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] StrobeLd = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLd   = CNT_W'(HOLD_CYC - 1);

  wr_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  strobe_q, strobe_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [REG_DATA_W-1:0] data_q, data_d;

  logic [CMD_W-1:0]      fifo_rdata;
  logic                  fifo_full, fifo_empty, pop;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid_i),
    .wdata_i ({cmd_addr_i, cmd_data_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (level_o)
  );

  assign cmd_ready_o  = !fifo_full;
  assign busy_o       = !fifo_empty || (state_q != StIdle);
  assign bus_addr_o   = addr_q;
  assign bus_data_o   = data_q;
  assign bus_strobe_o = strobe_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_d  = fifo_rdata[CMD_W-1:REG_DATA_W];
          data_d  = fifo_rdata[REG_DATA_W-1:0];
          cnt_d   = SetupLd;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          strobe_d = 1'b1;
          cnt_d    = StrobeLd;
          state_d  = StStrobe;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          strobe_d = 1'b0;
          cnt_d    = HoldLd;
          state_d  = StHold;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          // Chain straight into the next command so back-to-back writes keep a fixed period.
          if (!fifo_empty) begin
            pop     = 1'b1;
            addr_d  = fifo_rdata[CMD_W-1:REG_DATA_W];
            data_d  = fifo_rdata[REG_DATA_W-1:0];
            cnt_d   = SetupLd;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_reg_write_master.sv
// Directed bench for reg_write_master: default-timing instance plus a minimum-length instance.
module tb_reg_write_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       d_valid = 1'b0, d_ready, d_strobe, d_busy;
  logic [2:0] d_addr = '0, d_baddr;
  logic [4:0] d_data = '0, d_bdata;
  logic [2:0] d_level;

  // Minimum-length instance
  logic       m_valid = 1'b0, m_ready, m_strobe, m_busy;
  logic [2:0] m_addr = '0, m_baddr;
  logic [4:0] m_data = '0, m_bdata;
  logic [1:0] m_level;

  reg_write_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (d_valid),
    .cmd_ready_o  (d_ready),
    .cmd_addr_i   (d_addr),
    .cmd_data_i   (d_data),
    .bus_addr_o   (d_baddr),
    .bus_data_o   (d_bdata),
    .bus_strobe_o (d_strobe),
    .busy_o       (d_busy),
    .level_o      (d_level)
  );

  reg_write_master #(
    .DEPTH      (2),
    .SETUP_CYC  (1),
    .STROBE_CYC (1),
    .HOLD_CYC   (1)
  ) dut_min (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (m_valid),
    .cmd_ready_o  (m_ready),
    .cmd_addr_i   (m_addr),
    .cmd_data_i   (m_data),
    .bus_addr_o   (m_baddr),
    .bus_data_o   (m_bdata),
    .bus_strobe_o (m_strobe),
    .busy_o       (m_busy),
    .level_o      (m_level)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb_def[$];
  logic [7:0] sb_min[$];
  int d_rise_q[$];
  int m_rise_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: pops the scoreboard on each rising strobe and checks the pulse width.
  logic d_prev = 1'b0, m_prev = 1'b0;
  int   d_hi = 0, m_hi = 0;
  logic [7:0] d_exp, m_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      d_prev = 1'b0;
      m_prev = 1'b0;
    end else begin
      if (d_strobe && !d_prev) begin
        d_rise_q.push_back(cyc);
        d_hi = 1;
        chk("def strobe has queued cmd", (sb_def.size() > 0), 1);
        if (sb_def.size() > 0) begin
          d_exp = sb_def.pop_front();
          chk("def bus_addr", d_baddr, d_exp[7:5]);
          chk("def bus_data", d_bdata, d_exp[4:0]);
        end
      end else if (d_strobe) begin
        d_hi++;
      end else if (d_prev) begin
        chk("def strobe width", d_hi, 120);
      end
      if (m_strobe && !m_prev) begin
        m_rise_q.push_back(cyc);
        m_hi = 1;
        chk("min strobe has queued cmd", (sb_min.size() > 0), 1);
        if (sb_min.size() > 0) begin
          m_exp = sb_min.pop_front();
          chk("min bus_addr", m_baddr, m_exp[7:5]);
          chk("min bus_data", m_bdata, m_exp[4:0]);
        end
      end else if (m_strobe) begin
        m_hi++;
      end else if (m_prev) begin
        chk("min strobe width", m_hi, 1);
      end
      d_prev = d_strobe;
      m_prev = m_strobe;
    end
  end

  task automatic push(input bit which, input logic [2:0] a, input logic [4:0] d, output int t);
    int n = 0;
    @(negedge clk);
    if (which) begin m_valid = 1'b1; m_addr = a; m_data = d; end
    else begin d_valid = 1'b1; d_addr = a; d_data = d; end
    while (((which ? m_ready : d_ready) == 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push ready wait", (n < 2000), 1);
    @(posedge clk);
    #1;
    t = cyc;
    if (which) begin m_valid = 1'b0; sb_min.push_back({a, d}); end
    else begin d_valid = 1'b0; sb_def.push_back({a, d}); end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input bit which, input int budget);
    int n = 0;
    @(negedge clk);
    while ((which ? m_busy : d_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(which ? "min drain" : "def drain", (n < budget), 1);
  endtask

  initial begin
    int t, t1, t6, ta, tc, base;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset strobe", d_strobe, 0);
    chk("reset level", d_level, 0);
    chk("reset busy", d_busy, 0);
    chk("reset ready", d_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset addr", d_baddr, 0);
    chk("post-reset data", d_bdata, 0);

    // Single write
    push(1'b0, 3'd3, 5'h15, t);
    wait_to(t + 1);
    chk("single addr", d_baddr, 3);
    chk("single data", d_bdata, 5'h15);
    chk("single level", d_level, 0);
    wait_to(t + 60);
    chk("single strobe pre", d_strobe, 0);
    wait_to(t + 61);
    chk("single strobe rise", d_strobe, 1);
    wait_to(t + 180);
    chk("single strobe last", d_strobe, 1);
    wait_to(t + 181);
    chk("single strobe fall", d_strobe, 0);
    wait_to(t + 240);
    chk("single busy in hold", d_busy, 1);
    wait_to(t + 241);
    chk("single busy low", d_busy, 0);
    chk("single addr kept", d_baddr, 3);

    // Back-to-back
    d_rise_q.delete();
    push(1'b0, 3'd1, 5'h01, t);
    push(1'b0, 3'd2, 5'h02, base);
    push(1'b0, 3'd5, 5'h1F, base);
    push(1'b0, 3'd7, 5'h00, base);
    wait_idle(1'b0, 2000);
    chk("b2b strobes", d_rise_q.size(), 4);
    chk("b2b first rise", d_rise_q[0], t + 61);
    for (int i = 1; i < d_rise_q.size(); i++)
      chk("b2b period", d_rise_q[i] - d_rise_q[i-1], 240);
    chk("b2b sb empty", sb_def.size(), 0);

    // Backpressure
    d_rise_q.delete();
    push(1'b0, 3'd0, 5'h0A, t1);
    push(1'b0, 3'd1, 5'h0B, t);
    push(1'b0, 3'd2, 5'h0C, t);
    push(1'b0, 3'd3, 5'h0D, t);
    push(1'b0, 3'd4, 5'h0E, t);
    @(negedge clk);
    chk("bp level full", d_level, 4);
    chk("bp ready low", d_ready, 0);
    push(1'b0, 3'd6, 5'h10, t6);
    chk("bp held push edge", t6, t1 + 242);
    wait_idle(1'b0, 3000);
    chk("bp strobes", d_rise_q.size(), 6);
    chk("bp sb empty", sb_def.size(), 0);

    // Reset mid-strobe
    push(1'b0, 3'd5, 5'h05, t);
    push(1'b0, 3'd6, 5'h06, base);
    push(1'b0, 3'd7, 5'h07, base);
    wait_to(t + 111);
    chk("rst pre strobe", d_strobe, 1);
    chk("rst pre level", d_level, 2);
    rst_n = 1'b0;
    #1;
    chk("rst strobe", d_strobe, 0);
    chk("rst addr", d_baddr, 0);
    chk("rst data", d_bdata, 0);
    chk("rst level", d_level, 0);
    chk("rst busy", d_busy, 0);
    chk("rst ready", d_ready, 1);
    d_valid = 1'b1; d_addr = 3'd2; d_data = 5'h12;
    repeat (3) @(negedge clk);
    chk("rst push ignored", d_level, 0);
    d_valid = 1'b0;
    sb_def.delete();
    @(negedge clk);
    rst_n = 1'b1;
    base = d_rise_q.size();
    repeat (300) @(negedge clk);
    chk("rst no replay", d_rise_q.size(), base);
    chk("rst idle busy", d_busy, 0);

    // Minimum lengths, DEPTH=2
    push(1'b1, 3'd1, 5'h11, t);
    push(1'b1, 3'd2, 5'h12, base);
    push(1'b1, 3'd3, 5'h13, base);
    @(negedge clk);
    chk("min level full", m_level, 2);
    chk("min ready low", m_ready, 0);
    wait_idle(1'b1, 200);
    chk("min strobes", m_rise_q.size(), 3);
    chk("min first rise", m_rise_q[0], t + 2);
    for (int i = 1; i < m_rise_q.size(); i++)
      chk("min period", m_rise_q[i] - m_rise_q[i-1], 3);
    push(1'b1, 3'd4, 5'h14, t);
    push(1'b1, 3'd5, 5'h15, t);
    wait_idle(1'b1, 200);
    chk("min wrap strobes", m_rise_q.size(), 5);
    chk("min sb empty", sb_min.size(), 0);

    // Push on the HOLD->SETUP pop edge
    push(1'b0, 3'd1, 5'h03, ta);
    push(1'b0, 3'd2, 5'h1C, t);
    wait_to(ta + 239);
    chk("pope level before", d_level, 1);
    push(1'b0, 3'd3, 5'h09, tc);
    chk("pope push edge", tc, ta + 241);
    chk("pope level same", d_level, 1);
    chk("pope bus addr", d_baddr, 2);
    chk("pope bus data", d_bdata, 5'h1C);
    wait_idle(1'b0, 2000);
    chk("pope sb empty", sb_def.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
